// File: rtl/systolic_sequencer_if.sv
// Handshake and memory-control bundle between the systolic sequencer and its surroundings.
// The master side is the sequencer; the slave side is the host/datapath that answers it.
interface systolic_sequencer_if #(
  parameter int INSTR_W = 4,
  parameter int COL_W   = 8,
  parameter int OADDR_W = 7,
  parameter int PC_W    = 3
);
  logic               ap_start;
  logic               ap_done;
  logic               busy;
  logic               instr_rd_en;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic               pe_clr;
  logic               feed_en;
  logic [COL_W-1:0]   col_addr;
  logic               out_wr_en;
  logic [OADDR_W-1:0] out_base;

  modport master (
    input  ap_start, instr_data,
    output ap_done, busy, instr_rd_en, instr_addr, pe_clr,
           feed_en, col_addr, out_wr_en, out_base
  );

  modport slave (
    output ap_start, instr_data,
    input  ap_done, busy, instr_rd_en, instr_addr, pe_clr,
           feed_en, col_addr, out_wr_en, out_base
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Control FSM for the 4x4 systolic matmul: fetch K, clear, feed K columns, drain, commit tile.
// Every output is registered and computed from the next state, so it lines up with the state.
module systolic_sequencer #(
  parameter int NUM_INSTR    = 8,
  parameter int INSTR_W      = 4,
  parameter int COL_W        = 8,
  parameter int OADDR_W      = 7,
  parameter int TILE_WORDS   = 16,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_sequencer_if.master bus
);
  localparam int PC_W    = $clog2(NUM_INSTR);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    slot_q, slot_d;
  logic [COL_W-1:0]   col_base_q, col_base_d;
  logic [INSTR_W-1:0] k_q, k_d;
  logic [INSTR_W-1:0] feed_q, feed_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic               ap_done_q, ap_done_d;
  logic               busy_q, busy_d;
  logic               instr_rd_en_q, instr_rd_en_d;
  logic [PC_W-1:0]    instr_addr_q, instr_addr_d;
  logic               pe_clr_q, pe_clr_d;
  logic               feed_en_q, feed_en_d;
  logic [COL_W-1:0]   col_addr_q, col_addr_d;
  logic               out_wr_en_q, out_wr_en_d;
  logic [OADDR_W-1:0] out_base_q, out_base_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    slot_d     = slot_q;
    col_base_d = col_base_q;
    k_d        = k_q;
    feed_d     = feed_q;
    drain_d    = drain_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.ap_start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          slot_d     = '0;
          col_base_d = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        k_d     = bus.instr_data;
        state_d = (bus.instr_data == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_FEED;
        feed_d  = '0;
      end
      S_FEED: begin
        if (feed_q == k_q - INSTR_W'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          feed_d = feed_q + INSTR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = S_WRITE;
        else                                       drain_d = drain_q + DRAIN_W'(1);
      end
      S_WRITE: begin
        col_base_d = col_base_q + COL_W'(k_q);
        slot_d     = slot_q + PC_W'(1);
        pc_d       = pc_q + PC_W'(1);
        state_d    = (pc_q == PC_W'(NUM_INSTR - 1)) ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered; addresses are zero outside their strobe.
    instr_rd_en_d = (state_d == S_FETCH);
    instr_addr_d  = (state_d == S_FETCH) ? pc_d : '0;
    pe_clr_d      = (state_d == S_CLEAR);
    feed_en_d     = (state_d == S_FEED);
    col_addr_d    = (state_d == S_FEED) ? col_base_d + COL_W'(feed_d) : '0;
    out_wr_en_d   = (state_d == S_WRITE);
    out_base_d    = (state_d == S_WRITE) ? OADDR_W'(slot_d * TILE_WORDS) : '0;
    ap_done_d     = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      slot_q        <= '0;
      col_base_q    <= '0;
      k_q           <= '0;
      feed_q        <= '0;
      drain_q       <= '0;
      ap_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      instr_rd_en_q <= 1'b0;
      instr_addr_q  <= '0;
      pe_clr_q      <= 1'b0;
      feed_en_q     <= 1'b0;
      col_addr_q    <= '0;
      out_wr_en_q   <= 1'b0;
      out_base_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      slot_q        <= slot_d;
      col_base_q    <= col_base_d;
      k_q           <= k_d;
      feed_q        <= feed_d;
      drain_q       <= drain_d;
      ap_done_q     <= ap_done_d;
      busy_q        <= busy_d;
      instr_rd_en_q <= instr_rd_en_d;
      instr_addr_q  <= instr_addr_d;
      pe_clr_q      <= pe_clr_d;
      feed_en_q     <= feed_en_d;
      col_addr_q    <= col_addr_d;
      out_wr_en_q   <= out_wr_en_d;
      out_base_q    <= out_base_d;
    end
  end

  assign bus.ap_done     = ap_done_q;
  assign bus.busy        = busy_q;
  assign bus.instr_rd_en = instr_rd_en_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.pe_clr      = pe_clr_q;
  assign bus.feed_en     = feed_en_q;
  assign bus.col_addr    = col_addr_q;
  assign bus.out_wr_en   = out_wr_en_q;
  assign bus.out_base    = out_base_q;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: directed programs, expected columns/bases queued up front
// and popped by an independent monitor whenever feed_en or out_wr_en is seen.
module tb_systolic_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_sequencer_if bus ();
  systolic_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] imem [8];
  always @(posedge clk) if (bus.instr_rd_en) bus.instr_data <= imem[bus.instr_addr];

  int checks = 0;
  int errors = 0;

  logic [7:0] col_q [$];
  logic [6:0] base_q [$];
  int fetch_cnt, wr_cnt, clr_cnt;
  logic [7:0] last_col;
  logic [6:0] last_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {bus.instr_rd_en, bus.pe_clr, bus.feed_en, bus.out_wr_en, bus.ap_done, bus.busy};
  endfunction

  // Monitor: pops an expected value for every feed or commit the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.instr_rd_en) fetch_cnt++;
      if (bus.pe_clr) clr_cnt++;
      if (bus.feed_en) begin
        if (col_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_feed: got col_addr %0d expected no feed", bus.col_addr);
        end else begin
          last_col = bus.col_addr;
          check("col_addr", {24'b0, bus.col_addr}, {24'b0, col_q.pop_front()});
        end
      end
      if (bus.out_wr_en) begin
        wr_cnt++;
        if (base_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got out_base %0d expected no write", bus.out_base);
        end else begin
          last_base = bus.out_base;
          check("out_base", {25'b0, bus.out_base}, {25'b0, base_q.pop_front()});
        end
      end
    end
  end

  // Queue the columns and tile bases that the loaded program must produce.
  task automatic expect_program();
    logic [7:0] col = 8'd0;
    logic [6:0] base = 7'd0;
    col_q.delete();
    base_q.delete();
    for (int pc = 0; pc < 8; pc++) begin
      if (imem[pc] == 4'd0) break;
      for (int i = 0; i < int'(imem[pc]); i++) begin
        col_q.push_back(col);
        col++;
      end
      base_q.push_back(base);
      base += 7'd16;
    end
    fetch_cnt = 0; wr_cnt = 0; clr_cnt = 0;
  endtask

  // Returns at the negedge of cycle 1 (the FETCH cycle).
  task automatic start_pulse();
    @(negedge clk); bus.ap_start = 1'b1;
    @(negedge clk); bus.ap_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    while (!bus.ap_done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, bus.ap_done}, 32'd1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_cols_left"}, col_q.size(), 0);
    check({name, "_bases_left"}, base_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp;
    rst = 1'b1;
    bus.ap_start = 1'b0;
    for (int i = 0; i < 8; i++) imem[i] = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {26'b0, strobes()}, 32'd0);
    check("reset_addrs", {14'b0, bus.instr_addr, bus.col_addr, bus.out_base}, 32'd0);
    rst = 1'b0;

    // Program [4,0]: cycle-exact strobe timeline.
    imem[0] = 4'd4;
    expect_program();
    start_pulse();
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) @(negedge clk);
      exp = '0;
      if (c == 1 || c == 16) exp[5] = 1'b1;
      if (c == 3) exp[4] = 1'b1;
      if (c >= 4 && c <= 7) exp[3] = 1'b1;
      if (c == 15) exp[2] = 1'b1;
      if (c == 18) exp[1] = 1'b1;
      if (c <= 17) exp[0] = 1'b1;
      check($sformatf("k4_cycle%0d", c), {26'b0, strobes()}, {26'b0, exp});
    end
    check_drained("k4");

    // Program [4,2,3,0].
    imem[0] = 4'd4; imem[1] = 4'd2; imem[2] = 4'd3; imem[3] = 4'd0;
    expect_program();
    start_pulse();
    wait_done("prog3_done", 200);
    check("prog3_writes", wr_cnt, 3);
    check("prog3_fetches", fetch_cnt, 4);
    check("prog3_last_col", {24'b0, last_col}, 32'd8);
    check("prog3_last_base", {25'b0, last_base}, 32'd32);
    check_drained("prog3");

    // Restart from DONE: ap_done drops at once, program reruns from pc 0.
    expect_program();
    start_pulse();
    check("restart_done_low", {31'b0, bus.ap_done}, 32'd0);
    check("restart_fetch_pc0", {28'b0, bus.instr_rd_en, bus.instr_addr}, 32'h8);
    wait_done("restart_done", 200);
    check("restart_writes", wr_cnt, 3);
    check_drained("restart");

    // Program [0]: straight to DONE after FETCH, WAIT.
    imem[0] = 4'd0;
    expect_program();
    start_pulse();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      exp = (c == 1) ? 6'b100001 : (c == 2) ? 6'b000001 : 6'b000010;
      check($sformatf("k0_cycle%0d", c), {26'b0, strobes()}, {26'b0, exp});
    end
    check("k0_clears", clr_cnt, 0);
    check("k0_writes", wr_cnt, 0);

    // Eight K=15 instructions: full column and slot range, no ninth fetch.
    for (int i = 0; i < 8; i++) imem[i] = 4'd15;
    expect_program();
    start_pulse();
    wait_done("k15x8_done", 400);
    check("k15x8_fetches", fetch_cnt, 8);
    check("k15x8_writes", wr_cnt, 8);
    check("k15x8_last_col", {24'b0, last_col}, 32'd119);
    check("k15x8_last_base", {25'b0, last_base}, 32'd112);
    check_drained("k15x8");

    // ap_start mid-FEED is ignored; rst mid-FEED returns to IDLE with all outputs low.
    for (int i = 0; i < 8; i++) imem[i] = 4'd0;
    imem[0] = 4'd15;
    expect_program();
    start_pulse();
    for (int n = 0; n < 10 && !bus.feed_en; n++) @(negedge clk);
    check("feed_reached", {31'b0, bus.feed_en}, 32'd1);
    @(negedge clk); bus.ap_start = 1'b1;
    @(negedge clk); bus.ap_start = 1'b0;
    check("start_ignored_in_feed", {26'b0, strobes()}, 32'b001001);
    rst = 1'b1;
    @(negedge clk);
    check("rst_feed_strobes", {26'b0, strobes()}, 32'd0);
    check("rst_feed_addrs", {14'b0, bus.instr_addr, bus.col_addr, bus.out_base}, 32'd0);
    rst = 1'b0;
    col_q.delete();
    base_q.delete();
    repeat (3) @(negedge clk);
    check("idle_after_rst", {26'b0, strobes()}, 32'd0);
    imem[0] = 4'd2;
    expect_program();
    start_pulse();
    check("post_rst_fetch_pc0", {28'b0, bus.instr_rd_en, bus.instr_addr}, 32'h8);
    wait_done("post_rst_done", 100);
    check("post_rst_writes", wr_cnt, 1);
    check_drained("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Control FSM that runs the 4x4 systolic matrix-multiply datapath from a stored instruction list.
- Per instruction it:
  - fetches the inner dimension K from instruction memory;
  - clears the PE accumulators;
  - streams K operand columns from the A/B input memories;
  - waits for the array to drain;
  - commits the 16 results to output memory at a fresh 16-word slot.
- Sits between the top-level ap_start/ap_done handshake and the memory read/write enables. It replaces free-running memory counters with explicit addresses.

Parameters:
- NUM_INSTR, 8, instruction slots; program ends on a zero instruction or after the last slot.
- INSTR_W, 4, instruction width; value is K, the inner dimension (1..15); 0 = end of program.
- COL_W, 8, input-memory column address width.
- OADDR_W, 7, output-memory word address width.
- TILE_WORDS, 16, results written per instruction.
- DRAIN_CYCLES, 7, cycles between the last feed and writeback (array skew plus read latency).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ap_start  in  1  start pulse, sampled only in IDLE or DONE
- ap_done  out  1  level; high in DONE until next accepted start or rst
- busy  out  1  high in every state except IDLE and DONE
- instr_rd_en  out  1  instruction read strobe
- instr_addr  out  3  instruction index (log2 NUM_INSTR)
- instr_data  in  INSTR_W  instruction value, valid the cycle after instr_rd_en
- pe_clr  out  1  one-cycle accumulator clear to all PEs
- feed_en  out  1  A/B column read enable
- col_addr  out  COL_W  column address for A and B memories
- out_wr_en  out  1  one-cycle commit of all 16 PE results
- out_base  out  OADDR_W  base word address of the committed tile

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - Internal pc, col_base, slot, feed counter and drain counter are all 0.
  - rst overrides every state, including mid-FEED and mid-WRITE. Nothing is committed that cycle.
- States: IDLE, FETCH, WAIT, CLEAR, FEED, DRAIN, WRITE, DONE.
- IDLE/DONE:
  - On ap_start=1: go to FETCH, clear pc, col_base and slot, drop ap_done.
  - ap_start is ignored in all other states.
- FETCH (1 cycle): instr_rd_en=1, instr_addr=pc. Next state is WAIT.
- WAIT (1 cycle): capture K=instr_data.
  - If K==0, go to DONE.
  - Otherwise go to CLEAR.
- CLEAR (1 cycle): pe_clr=1. Next state is FEED, with the feed counter at 0.
- FEED (K cycles): feed_en=1, col_addr=col_base+i for i=0..K-1. After the cycle with i=K-1, go to DRAIN.
- DRAIN (DRAIN_CYCLES cycles): all strobes low. Then go to WRITE.
- WRITE (1 cycle): out_wr_en=1, out_base=slot*TILE_WORDS. Then update:
  - col_base += K, modulo 2^COL_W;
  - slot += 1;
  - pc += 1.
  - If the old pc was NUM_INSTR-1, go to DONE; otherwise go to FETCH.
- DONE: ap_done=1, busy=0. ap_done stays high until an accepted ap_start or rst.
- Timing:
  - Per nonzero instruction: K+4+DRAIN_CYCLES cycles from FETCH to WRITE inclusive (K+11 at defaults).
  - Zero instruction: 2 cycles (FETCH, WAIT) before DONE.
- Widths:
  - col_addr wraps modulo 2^COL_W. The defaults cannot exceed 120 columns.
  - out_base wraps modulo 2^OADDR_W. The defaults reach at most 112.
- Outputs are registered. Strobes are high only in their named states.

Test Plan:
- Program [4,0], ap_start at cycle 0:
  - FETCH cycle 1; pe_clr cycle 3; feed_en cycles 4-7 with col_addr 0,1,2,3;
  - out_wr_en cycle 15 with out_base=0;
  - FETCH cycle 16; ap_done rises cycle 18.
- Program [4,2,3,0]:
  - col_addr sequences 0-3, 4-5, 6-8;
  - out_base 0, 16, 32;
  - exactly 3 out_wr_en pulses, then ap_done=1.
- Program [0]: ap_start -> no pe_clr/feed_en/out_wr_en; ap_done=1 two cycles after FETCH; busy never high after WAIT.
- Eight nonzero instructions of K=15:
  - final out_base=112 and final col_addr=119;
  - DONE entered after the 8th WRITE without a 9th FETCH.
- ap_start pulsed during FEED is ignored. rst asserted during FEED:
  - next cycle all outputs are 0 and the state is IDLE;
  - a later ap_start restarts at instr_addr 0, col_addr 0.
- After DONE, a new ap_start:
  - ap_done falls next cycle;
  - the program reruns from pc 0 with out_base restarting at 0.
